// File: rtl/vx_dot8_accum.sv
// vx_dot8_accum: per-warp, per-lane accumulation of packed-int8 dot8 results across
// first/last delimited beat sequences. Define DOT8_ACC_SAT_EN for signed-saturating adds.
module vx_dot8_accum #(
  parameter int NUM_LANES = 1,
  parameter int NUM_WARPS = 4,
  parameter int TAG_WIDTH = 1,
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_LANES*32-1:0]   in_data,
  input  logic [NUM_LANES-1:0]      in_tmask,
  input  logic [WID_W-1:0]          in_wid,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_LANES*32-1:0]   out_data,
  output logic [NUM_LANES-1:0]      out_tmask,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic [7:0]                out_count,
  output logic                      proto_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;
  localparam logic [7:0] CNT_MAX  = 8'hFF;

  // Two's-complement lane add; the saturating build clamps on signed overflow.
  function automatic logic [31:0] lane_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
`ifdef DOT8_ACC_SAT_EN
    if ((a[31] == b[31]) && (s[31] != a[31]))
      s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return s;
  endfunction

  logic [0:0]  state_q [NUM_WARPS];
  logic [31:0] acc_q   [NUM_WARPS][NUM_LANES];
  logic [7:0]  cnt_q   [NUM_WARPS];

  logic                    accept;
  logic                    cur_idle;
  logic                    restart;
  logic                    seq_err;
  logic [31:0]             lane_base [NUM_LANES];
  logic [NUM_LANES*32-1:0] sum_d;
  logic [7:0]              cnt_d;

  // A stalled result blocks every beat, last or not, so ordering stays trivial.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign cur_idle = (state_q[in_wid] == ST_IDLE);
  assign restart  = in_first || cur_idle;
  assign seq_err  = (in_first && !cur_idle) || (!in_first && cur_idle);

  assign cnt_d = restart                      ? 8'd1    :
                 (cnt_q[in_wid] == CNT_MAX)   ? CNT_MAX :
                                                cnt_q[in_wid] + 8'd1;

  // NOTE: every output of a combinational block is assigned on every path (here by
  // defaulting first), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_base[i] = restart ? 32'd0 : acc_q[in_wid][i];
      sum_d[i*32 +: 32] = in_tmask[i] ? lane_add(lane_base[i], in_data[i*32 +: 32])
                                      : lane_base[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order or block count.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: accumulators are cleared too; IDLE already masks them, but this keeps
      // post-reset contents deterministic at the cost of reset fan-out on the array.
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= ST_IDLE;
        cnt_q[w]   <= 8'd0;
        for (int l = 0; l < NUM_LANES; l++)
          acc_q[w][l] <= 32'd0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tmask <= '0;
      out_tag   <= '0;
      out_count <= 8'd0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        if (seq_err)
          proto_err <= 1'b1;
        if (in_last) begin
          state_q[in_wid] <= ST_IDLE;
          cnt_q[in_wid]   <= 8'd0;
          for (int l = 0; l < NUM_LANES; l++)
            acc_q[in_wid][l] <= 32'd0;
        end else begin
          state_q[in_wid] <= ST_ACCUM;
          cnt_q[in_wid]   <= cnt_d;
          for (int l = 0; l < NUM_LANES; l++)
            acc_q[in_wid][l] <= sum_d[l*32 +: 32];
        end
      end

      // A new last beat in the drain cycle reloads the register for full throughput.
      if (accept && in_last) begin
        out_valid <= 1'b1;
        out_data  <= sum_d;
        out_tmask <= in_tmask;
        out_tag   <= in_tag;
        out_count <= cnt_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vx_dot8_accum.sv
// Scoreboard bench for vx_dot8_accum with two lanes and a 2-bit tag; expectations are
// pushed when a last beat is driven and compared when the result handshakes.
module tb_vx_dot8_accum;

  localparam int NL = 2;
  localparam int NW = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [NL*32-1:0] in_data;
  logic [NL-1:0] in_tmask;
  logic [1:0]    in_wid;
  logic          in_first;
  logic          in_last;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [NL*32-1:0] out_data;
  logic [NL-1:0] out_tmask;
  logic [TW-1:0] out_tag;
  logic [7:0]    out_count;
  logic          proto_err;

  vx_dot8_accum #(.NUM_LANES(NL), .NUM_WARPS(NW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tmask(in_tmask),
    .in_wid(in_wid), .in_first(in_first), .in_last(in_last), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tmask(out_tmask), .out_tag(out_tag), .out_count(out_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NL*32-1:0] data;
    logic [NL-1:0]    tmask;
    logic [TW-1:0]    tag;
    logic [7:0]       count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef DOT8_ACC_SAT_EN
  localparam logic [31:0] OVF_POS  = 32'h7FFF_FFFF;
  localparam logic [31:0] OVF_NEG  = 32'h8000_0000;
  localparam logic [31:0] CLAMP_UP = 32'h7FFF_FFFE;
`else
  localparam logic [31:0] OVF_POS  = 32'h8000_0010;
  localparam logic [31:0] OVF_NEG  = 32'h7FFF_FFF0;
  localparam logic [31:0] CLAMP_UP = 32'h8000_000F;
`endif

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] d1, input logic [31:0] d0,
                            input logic [NL-1:0] tm, input logic [TW-1:0] tg,
                            input logic [7:0] cnt);
    exp_t e;
    e.data  = {d1, d0};
    e.tmask = tm;
    e.tag   = tg;
    e.count = cnt;
    exp_q.push_back(e);
  endtask

  // Drive one beat and hold it until accepted (bounded).
  task automatic send(input logic [1:0] wid, input logic first, input logic last,
                      input logic [31:0] d1, input logic [31:0] d0,
                      input logic [NL-1:0] tm, input logic [TW-1:0] tg);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_wid = wid; in_first = first; in_last = last;
    in_data = {d1, d0}; in_tmask = tm; in_tag = tg;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    exp_q.delete();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: a handshake happens at the next posedge when both are high here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data",  64'(out_data),  64'(e.data));
          check("out_tmask", 64'(out_tmask), 64'(e.tmask));
          check("out_tag",   64'(out_tag),   64'(e.tag));
          check("out_count", 64'(out_count), 64'(e.count));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_tmask = '0; in_wid = '0;
    in_first = 1'b0; in_last = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data",  64'(out_data),  64'd0);
    check("reset_out_tmask", 64'(out_tmask), 64'd0);
    check("reset_out_tag",   64'(out_tag),   64'd0);
    check("reset_out_count", 64'(out_count), 64'd0);
    check("reset_proto_err", 64'(proto_err), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    reset = 1'b0;

    // Single first=last beat; masked lane 1 must stay zero. Result one cycle later.
    expect_out(32'd0, 32'd5, 2'b01, 2'd1, 8'd1);
    send(2'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'd5, 2'b01, 2'd1);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("single_proto_err",  64'(proto_err), 64'd0);

    // Three-beat sequence: 10 - 3 + 100 = 107; lane 1: 1 + 2 + 3 = 6.
    expect_out(32'd6, 32'd107, 2'b11, 2'd2, 8'd3);
    send(2'd0, 1'b1, 1'b0, 32'd1, 32'd10,         2'b11, 2'd0);
    send(2'd0, 1'b0, 1'b0, 32'd2, 32'hFFFF_FFFD,  2'b11, 2'd0);
    send(2'd0, 1'b0, 1'b1, 32'd3, 32'd100,        2'b11, 2'd2);

    // Interleaved warps 0 and 1, each result carries its own last-beat tag.
    expect_out(32'd0, 32'd12,         2'b01, 2'd1, 8'd2);
    expect_out(32'd0, 32'hFFFF_FFFE,  2'b01, 2'd2, 8'd2);
    send(2'd0, 1'b1, 1'b0, 32'd0, 32'd5,          2'b01, 2'd0);
    send(2'd1, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF,  2'b01, 2'd0);
    send(2'd0, 1'b0, 1'b1, 32'd0, 32'd7,          2'b01, 2'd1);
    send(2'd1, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF,  2'b01, 2'd2);

    // Positive overflow on lane 0, negative overflow on lane 1.
    expect_out(OVF_NEG, OVF_POS, 2'b11, 2'd3, 8'd2);
    send(2'd2, 1'b1, 1'b0, 32'h8000_0010, 32'h7FFF_FFF0, 2'b11, 2'd0);
    send(2'd2, 1'b0, 1'b1, 32'hFFFF_FFE0, 32'h0000_0020, 2'b11, 2'd3);

    // Accumulation continues from the overflowed value.
    expect_out(32'd0, CLAMP_UP, 2'b01, 2'd0, 8'd3);
    send(2'd3, 1'b1, 1'b0, 32'd0, 32'h7FFF_FFF0, 2'b01, 2'd0);
    send(2'd3, 1'b0, 1'b0, 32'd0, 32'h0000_0020, 2'b01, 2'd0);
    send(2'd3, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF, 2'b01, 2'd0);

    // Lane mask 01 then 11: lane0 = 4 + 1, lane1 = 1 (the 9 is masked).
    expect_out(32'd1, 32'd5, 2'b11, 2'd2, 8'd2);
    send(2'd1, 1'b1, 1'b0, 32'd9, 32'd4, 2'b01, 2'd0);
    send(2'd1, 1'b0, 1'b1, 32'd1, 32'd1, 2'b11, 2'd2);

    // 300-beat sequence: sum 300, beat count saturates at 255.
    expect_out(32'd0, 32'd300, 2'b01, 2'd1, 8'd255);
    for (int i = 0; i < 300; i++)
      send(2'd0, (i == 0), (i == 299), 32'd0, 32'd1, 2'b01, (i == 299) ? 2'd1 : 2'd0);
    drain();
    check("no_err_so_far", 64'(proto_err), 64'd0);

    // Stalled output: input blocked and output held for 5 cycles.
    out_ready = 1'b0;
    expect_out(32'd0, 32'd42, 2'b01, 2'd3, 8'd1);
    send(2'd2, 1'b1, 1'b1, 32'd0, 32'd42, 2'b01, 2'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_wid = 2'd3; in_first = 1'b1; in_last = 1'b1;
      in_data = {32'd0, 32'd99}; in_tmask = 2'b01; in_tag = 2'd0;
      #1;
      check("stall_in_ready",  64'(in_ready),  64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_data",  64'(out_data),  64'd42);
      check("stall_out_count", 64'(out_count), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Non-first beat to an IDLE warp: flagged and treated as first.
    expect_out(32'd0, 32'd8, 2'b01, 2'd0, 8'd1);
    send(2'd3, 1'b0, 1'b1, 32'd0, 32'd8, 2'b01, 2'd0);
    check("idle_nonfirst_err", 64'(proto_err), 64'd1);
    drain();

    // Reset mid-sequence with a pending output: everything is dropped.
    send(2'd1, 1'b1, 1'b0, 32'd0, 32'd50, 2'b01, 2'd0);
    out_ready = 1'b0;
    send(2'd0, 1'b1, 1'b1, 32'd0, 32'd77, 2'b01, 2'd1);
    pulse_reset();
    out_ready = 1'b1;
    expect_out(32'd0, 32'd4, 2'b01, 2'd2, 8'd1);
    send(2'd1, 1'b0, 1'b1, 32'd0, 32'd4, 2'b01, 2'd2);
    expect_out(32'd0, 32'd3, 2'b01, 2'd1, 8'd1);
    send(2'd0, 1'b1, 1'b1, 32'd0, 32'd3, 2'b01, 2'd1);
    drain();

    // First beat while accumulating: old partial discarded, error flagged.
    pulse_reset();
    expect_out(32'd0, 32'd7, 2'b01, 2'd3, 8'd1);
    send(2'd2, 1'b1, 1'b0, 32'd0, 32'd1000, 2'b01, 2'd0);
    send(2'd2, 1'b1, 1'b1, 32'd0, 32'd7,    2'b01, 2'd3);
    check("accum_first_err", 64'(proto_err), 64'd1);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
